// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//   FIFO of pending CPU stores sitting in front of a single-ported data
//   memory. Stores drain one per cycle in order; loads are checked against
//   every buffered entry so they see the youngest matching store. A
//   full-word match forwards the data. A partial-byte match stalls the load
//   until the entry has drained. A load that matches nothing takes the
//   memory port for a read, and draining waits for that cycle.
//
// Ports
//   clk                     rising-edge clock
//   reset                   asynchronous, active-high; empties the buffer
//   st_valid/st_ready       store handshake (dropped when not ready)
//   st_addr/data/be/pc      store address, data, byte enables, store PC
//   ld_valid, ld_addr       load request and address
//   ld_hit, ld_data         load forwarded from the buffer, with the word
//   ld_stall                load cannot complete this cycle
//   dm_we/addr/din/be/pc    data-memory port (write on drain, read on miss)
//   count                   number of occupied entries
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [3:0]               st_be,
    input  logic [31:0]              st_pc,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [31:0]              ld_addr,
    output logic                     ld_hit,
    output logic [31:0]              ld_data,
    output logic                     ld_stall,
    output logic                     dm_we,
    output logic [31:0]              dm_addr,
    output logic [31:0]              dm_din,
    output logic [3:0]               dm_be,
    output logic [31:0]              dm_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [29:0]   r_waddr [DEPTH];
    logic [31:0]   r_wdata [DEPTH];
    logic [3:0]    r_wbe   [DEPTH];
    logic [31:0]   r_wpc   [DEPTH];

    logic          w_ld;
    logic          w_match;
    logic [PW-1:0] w_match_idx;
    logic          w_match_full;
    logic          w_ld_miss;
    logic          w_drain;
    logic          w_enq;

    // Scan from the oldest entry to the youngest. A later hit overwrites an
    // earlier one, so the final result is the youngest matching store.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (CW'(k) < r_count &&
                r_waddr[r_head + PW'(k)] == ld_addr[31:2]) begin
                w_match     = 1'b1;
                w_match_idx = r_head + PW'(k);
            end
        end
    end

    assign w_ld         = ld_valid & ~reset;
    assign w_match_full = (r_wbe[w_match_idx] == 4'hF);
    assign w_ld_miss    = w_ld & ~w_match;
    // A missing load owns the memory port, so draining pauses that cycle.
    assign w_drain      = (r_count != '0) & ~w_ld_miss & ~reset;
    assign st_ready     = (r_count < CW'(DEPTH));
    assign w_enq        = st_valid & st_ready & ~reset;

    assign ld_hit   = w_ld & w_match & w_match_full;
    assign ld_stall = w_ld & w_match & ~w_match_full;
    assign ld_data  = ld_hit ? r_wdata[w_match_idx] : '0;
    assign count    = r_count;

    always_comb begin
        dm_we   = 1'b0;
        dm_addr = '0;
        dm_din  = '0;
        dm_be   = '0;
        dm_pc   = '0;
        if (w_ld_miss) begin
            dm_addr = {ld_addr[31:2], 2'b00};
        end else if (w_drain) begin
            dm_we   = 1'b1;
            dm_addr = {r_waddr[r_head], 2'b00};
            dm_din  = r_wdata[r_head];
            dm_be   = r_wbe[r_head];
            dm_pc   = r_wpc[r_head];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_drain) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload needs no reset: occupancy is tracked by head/count only.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_waddr[r_tail] <= st_addr[31:2];
            r_wdata[r_tail] <= st_data;
            r_wbe[r_tail]   <= st_be;
            r_wpc[r_tail]   <= st_pc;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic                   clk;
    logic                   reset;
    logic                   st_valid;
    logic [31:0]            st_addr;
    logic [31:0]            st_data;
    logic [3:0]             st_be;
    logic [31:0]            st_pc;
    logic                   st_ready;
    logic                   ld_valid;
    logic [31:0]            ld_addr;
    logic                   ld_hit;
    logic [31:0]            ld_data;
    logic                   ld_stall;
    logic                   dm_we;
    logic [31:0]            dm_addr;
    logic [31:0]            dm_din;
    logic [3:0]             dm_be;
    logic [31:0]            dm_pc;
    logic [$clog2(DEPTH):0] count;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_be(st_be), .st_pc(st_pc), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din),
        .dm_be(dm_be), .dm_pc(dm_pc), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: a plain queue of stores ----------
    typedef struct packed {
        logic [29:0] wa;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    ent_t m_hit;
    ent_t m_pend;
    bit   m_found, m_ld, m_miss, exp_enq, exp_drain;
    int   m_sz;
    logic        e_hit, e_stall, e_we;
    logic [31:0] e_data, e_addr, e_din, e_pc;
    logic [3:0]  e_be;

    initial begin
        exp_enq   = 0;
        exp_drain = 0;
    end

    always @(posedge reset) q.delete();

    always @(posedge clk) begin
        if (!reset) begin
            if (exp_drain) void'(q.pop_front());
            if (exp_enq) q.push_back(m_pend);
        end
    end

    // One compare per cycle, away from the clock edge.
    always @(negedge clk) begin
        m_sz    = q.size();
        m_found = 0;
        m_hit   = '0;
        for (int i = m_sz - 1; i >= 0; i--) begin
            if (!m_found && q[i].wa == ld_addr[31:2]) begin
                m_found = 1;
                m_hit   = q[i];
            end
        end
        m_ld    = ld_valid && !reset;
        e_hit   = m_ld && m_found && (m_hit.be == 4'hF);
        e_stall = m_ld && m_found && (m_hit.be != 4'hF);
        e_data  = e_hit ? m_hit.d : 32'h0;
        m_miss  = m_ld && !m_found;
        exp_drain = (m_sz > 0) && !m_miss && !reset;
        e_we = 0; e_addr = 0; e_din = 0; e_be = 0; e_pc = 0;
        if (m_miss) begin
            e_addr = {ld_addr[31:2], 2'b00};
        end else if (exp_drain) begin
            e_we   = 1;
            e_addr = {q[0].wa, 2'b00};
            e_din  = q[0].d;
            e_be   = q[0].be;
            e_pc   = q[0].pc;
        end
        exp_enq = st_valid && !reset && (m_sz < DEPTH);
        m_pend  = '{wa: st_addr[31:2], d: st_data, be: st_be, pc: st_pc};

        chk("count",    32'(count),    32'(m_sz));
        chk("st_ready", 32'(st_ready), 32'(m_sz < DEPTH));
        chk("ld_hit",   32'(ld_hit),   32'(e_hit));
        chk("ld_stall", 32'(ld_stall), 32'(e_stall));
        chk("ld_data",  ld_data,       e_data);
        chk("dm_we",    32'(dm_we),    32'(e_we));
        chk("dm_addr",  dm_addr,       e_addr);
        chk("dm_din",   dm_din,        e_din);
        chk("dm_be",    32'(dm_be),    32'(e_be));
        chk("dm_pc",    dm_pc,         e_pc);
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        st_valid = 0; st_addr = 0; st_data = 0; st_be = 0; st_pc = 0;
        ld_valid = 0; ld_addr = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [31:0] p);
        st_valid = 1; st_addr = a; st_data = d; st_be = b; st_pc = p;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1;
        idle();
        step();
        step();
        settle();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        chk("rst_ready", 32'(st_ready), 32'd1);
        step();
        reset = 0;

        // Single store drains on the following cycle.
        store(32'h10, 32'hDEADBEEF, 4'hF, 32'h3000);
        settle();
        chk("s1_ready", 32'(st_ready), 32'd1);
        chk("s1_count0", 32'(count), 32'd0);
        step();
        idle();
        settle();
        chk("s1_we", 32'(dm_we), 32'd1);
        chk("s1_addr", dm_addr, 32'h10);
        chk("s1_din", dm_din, 32'hDEADBEEF);
        chk("s1_pc", dm_pc, 32'h3000);
        step();
        settle();
        chk("s1_count_after", 32'(count), 32'd0);
        chk("s1_we_after", 32'(dm_we), 32'd0);
        step();

        // Fill while a missing load blocks draining.
        ld_valid = 1; ld_addr = 32'h100;
        for (int i = 0; i < 4; i++) begin
            store(32'h200 + 32'(4*i), 32'hA0 + 32'(i), 4'hF, 32'h4000 + 32'(4*i));
            step();
        end
        store(32'h210, 32'hA4, 4'hF, 32'h4010);
        settle();
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(st_ready), 32'd0);
        chk("full_rd_addr", dm_addr, 32'h100);
        chk("full_we", 32'(dm_we), 32'd0);
        step();
        st_valid = 0;
        settle();
        chk("fifth_dropped", 32'(count), 32'd4);
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("order_we", 32'(dm_we), 32'd1);
            chk("order_pc", dm_pc, 32'h4000 + 32'(4*i));
            chk("order_addr", dm_addr, 32'h200 + 32'(4*i));
            step();
        end
        settle();
        chk("order_empty", 32'(count), 32'd0);
        step();

        // Youngest full-word store is forwarded.
        ld_valid = 1; ld_addr = 32'h300;
        store(32'h20, 32'h11111111, 4'hF, 32'h4100);
        step();
        store(32'h20, 32'h22222222, 4'hF, 32'h4104);
        step();
        st_valid = 0; ld_addr = 32'h20;
        settle();
        chk("fwd_hit", 32'(ld_hit), 32'd1);
        chk("fwd_data", ld_data, 32'h22222222);
        chk("fwd_stall", 32'(ld_stall), 32'd0);
        chk("fwd_no_read", 32'(dm_we), 32'd1);
        chk("fwd_drain_pc", dm_pc, 32'h4100);
        step();
        idle();
        step();
        step();
        settle();
        chk("fwd_empty", 32'(count), 32'd0);
        step();

        // Partial store stalls the load until drained.
        store(32'h40, 32'h55AA55AA, 4'b0011, 32'h4200);
        step();
        st_valid = 0; ld_valid = 1; ld_addr = 32'h40;
        settle();
        chk("part_stall", 32'(ld_stall), 32'd1);
        chk("part_hit", 32'(ld_hit), 32'd0);
        chk("part_drain", 32'(dm_we), 32'd1);
        step();
        settle();
        chk("part_stall_end", 32'(ld_stall), 32'd0);
        chk("part_miss_rd", 32'(dm_we), 32'd0);
        chk("part_miss_addr", dm_addr, 32'h40);
        step();
        idle();

        // Asynchronous reset in the middle of a drain.
        ld_valid = 1; ld_addr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            store(32'h600 + 32'(4*i), 32'hC0 + 32'(i), 4'hF, 32'h4300 + 32'(4*i));
            step();
        end
        idle();
        settle();
        chk("mid_count", 32'(count), 32'd3);
        chk("mid_we", 32'(dm_we), 32'd1);
        #1;
        reset = 1;
        #1;
        chk("arst_we", 32'(dm_we), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_ready", 32'(st_ready), 32'd1);
        step();
        reset = 0;
        settle();
        chk("post_rst_we", 32'(dm_we), 32'd0);
        step();
        settle();
        chk("post_rst_we2", 32'(dm_we), 32'd0);
        step();

        // Pointer wrap-around.
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) store(32'h700 + 32'(4*k), 32'(k), 4'hF, 32'h5000 + 32'(4*k));
            else idle();
            settle();
            if (k >= 1) begin
                chk("wrap_we", 32'(dm_we), 32'd1);
                chk("wrap_pc", dm_pc, 32'h5000 + 32'(4*(k-1)));
                chk("wrap_din", dm_din, 32'(k-1));
            end
            step();
        end
        idle();

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset = 1;
                idle();
                step();
                reset = 0;
            end
            st_valid = ($urandom_range(0, 9) < 6);
            st_addr  = 32'h1000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
            st_data  = $urandom;
            st_be    = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            st_pc    = $urandom;
            ld_valid = ($urandom_range(0, 9) < 4);
            ld_addr  = 32'h1000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
            step();
        end
        idle();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4; number of buffered store entries; power of two, 2..8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 SHALL have port st_valid  input  1  CPU store request this cycle.
REQ-005 SHALL have ports st_addr  input  32, st_data  input  32, st_be  input  4, st_pc  input  32  store address, data, byte enables and store PC.
REQ-006 SHALL have port st_ready  output  1  buffer can accept a store.
REQ-007 SHALL have ports ld_valid  input  1 and ld_addr  input  32  CPU load request and address.
REQ-008 SHALL have ports ld_hit  output  1 and ld_data  output  32  load forwarded from buffer, with forwarded word.
REQ-009 SHALL have port ld_stall  output  1  load cannot complete this cycle.
REQ-010 SHALL have ports dm_we  output  1, dm_addr  output  32, dm_din  output  32, dm_be  output  4, dm_pc  output  32  single data-memory port.
REQ-011 SHALL have port count  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-012 SHALL hold entries {word address = addr[31:2], data, be, pc} in a FIFO with head/tail pointers wrapping modulo DEPTH.
REQ-013 SHALL assert st_ready combinationally when registered count < DEPTH; a draining entry in the same cycle does not free space until the next cycle.
REQ-014 SHALL enqueue at the tail on a rising edge when st_valid && st_ready; st_valid while !st_ready is dropped (the CPU holds it and retries).
REQ-015 SHALL compare ld_addr[31:2] against all occupied entries existing before the current edge; a store enqueued in the same cycle is not visible to that load.
REQ-016 SHALL, when the youngest matching entry has be = 4'hF, assert ld_hit = 1, drive ld_data = that entry's data and hold ld_stall = 0.
REQ-017 SHALL, when the youngest matching entry has be != 4'hF, assert ld_stall = 1, drive ld_hit = 0 and let draining continue until no match remains.
REQ-018 SHALL, when ld_valid and no entry matches, give the port to the load: dm_addr = {ld_addr[31:2],2'b00}, dm_we = 0; draining is suppressed that cycle.
REQ-019 SHALL otherwise, when count > 0, drain the head: dm_we = 1, dm_addr = {head addr,2'b00}, dm_din, dm_be, dm_pc = head fields; head advances at the next edge.
REQ-020 SHALL drive dm_we = 0 and dm_addr/dm_din/dm_be/dm_pc = 0 when idle (empty, no load).
REQ-021 SHALL update count by +1 on enqueue only, -1 on drain only, and leave it unchanged on simultaneous enqueue and drain.
REQ-022 SHALL drive ld_hit, ld_data and ld_stall to 0 whenever ld_valid = 0.
REQ-023 SHALL drain exactly one entry per non-suppressed cycle, in FIFO order, with 1-cycle latency from enqueue edge to earliest dm_we.

Reset
REQ-024 SHALL, on reset assertion, clear count, head and tail and discard all entries, combinationally forcing dm_we = 0 and st_ready = 1 without waiting for clk.
REQ-025 SHALL, out of reset, drive count = 0, dm_we = 0, all dm_* = 0, ld_hit = 0, ld_data = 0, ld_stall = 0.
REQ-026 SHALL ignore st_valid and ld_valid while reset = 1.

Verification
REQ-027 SHALL verify a single store of addr 0x10, data 0xDEADBEEF, be F, pc 0x3000: the next cycle dm_we = 1, dm_addr = 0x10, dm_din = 0xDEADBEEF, dm_pc = 0x3000, then count returns to 0.
REQ-028 SHALL verify 4 back-to-back stores with a held miss load to 0x100 blocking draining: count = 4, st_ready = 0; a 5th store is not accepted; after the load is released, 4 drains follow in order.
REQ-029 SHALL verify stores to 0x20 of 0x11111111 and then 0x22222222 (both be F) followed by a load of 0x20: ld_hit = 1, ld_data = 0x22222222, no DM read.
REQ-030 SHALL verify a store to 0x40 with be 4'b0011 followed by a load of 0x40: ld_stall = 1 until that entry drains, then the load misses and reads DM.
REQ-031 SHALL verify asserting reset with count = 3 mid-drain: dm_we falls within the same cycle, count = 0, and no further DM writes occur.
REQ-032 SHALL verify pointer wrap-around with 10 sequential stores through DEPTH = 4: all 10 are written in order with correct pc tags.
